muldiv_decode_stage: RTL and testbench

- Next-generation instruction decoder for the RISC-V pipeline CPU.
- Decodes RV32I and, when ENABLE_M=1, the RV32M multiply/divide group.
- Contains the ID/EX control register, so decoded control arrives registered at the EX stage.
- Sequences multi-cycle MUL/DIV occupancy of EX by raising a stall request to the hazard unit until the operation completes.

---
 rtl/muldiv_decode_stage.sv | 279 +++++++++++++++++++++++++++
 tb/tb_muldiv_decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_decode_stage.sv
// RV32I/RV32M instruction decoder with the ID/EX control register
// and stall sequencing for multi-cycle MUL/DIV occupancy of EX.
module muldiv_decode_stage #(
   parameter int ENABLE_M   = 1,
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 33,
   parameter int ALU_CTRL_W = 5
) (
   input  logic                  CPU_CLK,
   input  logic                  CPU_RST,
   input  logic [31:0]           InstrD,
   input  logic                  StallE,
   input  logic                  FlushE,
   output logic                  JalE,
   output logic                  JalrE,
   output logic                  MemToRegE,
   output logic                  LoadNpcE,
   output logic                  AluSrc1E,
   output logic [2:0]            RegWriteE,
   output logic [3:0]            MemWriteE,
   output logic [1:0]            RegReadE,
   output logic [2:0]            BranchTypeE,
   output logic [1:0]            AluSrc2E,
   output logic [2:0]            ImmTypeE,
   output logic [ALU_CTRL_W-1:0] AluContrlE,
   output logic                  MulDivE,
   output logic                  IllegalE,
   output logic                  MulDivStallReq,
   output logic                  MulDivDoneE
);

   typedef enum logic {IDLE, BUSY} state_t;

   typedef struct packed {
      logic                  jal;
      logic                  jalr;
      logic                  mem_to_reg;
      logic                  load_npc;
      logic                  alu_src1;
      logic [2:0]            reg_write;
      logic [3:0]            mem_write;
      logic [1:0]            reg_read;
      logic [2:0]            branch_type;
      logic [1:0]            alu_src2;
      logic [2:0]            imm_type;
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic                  mul_div;
      logic                  is_div;
      logic                  illegal;
   } ctrl_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [5:0] MUL_LD    = 6'(MUL_CYCLES - 2);
   localparam logic [5:0] DIV_LD    = 6'(DIV_CYCLES - 2);
   localparam logic       MUL_MULTI = (MUL_CYCLES > 1);
   localparam logic       DIV_MULTI = (DIV_CYCLES > 1);

   function automatic logic [ALU_CTRL_W-1:0] ac(input int v);
      return ALU_CTRL_W'(v);
   endfunction

   function automatic logic [ALU_CTRL_W-1:0] base_alu(
      input logic [2:0] f3
   );
      logic [ALU_CTRL_W-1:0] r;
      unique case (f3)
         3'b000:  r = ac(3);
         3'b001:  r = ac(0);
         3'b010:  r = ac(8);
         3'b011:  r = ac(9);
         3'b100:  r = ac(5);
         3'b101:  r = ac(1);
         3'b110:  r = ac(6);
         default: r = ac(7);
      endcase
      return r;
   endfunction

   logic [6:0] opcode;
   logic [2:0] fn3;
   logic [6:0] fn7;
   logic       ok;
   ctrl_t      dec;
   ctrl_t      e;
   state_t     state;
   logic [5:0] cnt;
   logic       fresh;
   logic       start;
   logic       multi;
   logic       last;
   logic       hold;
   logic       unused_bits;

   assign opcode      = InstrD[6:0];
   assign fn3         = InstrD[14:12];
   assign fn7         = InstrD[31:25];
   assign unused_bits = ^{InstrD[24:15], InstrD[11:7]};

   always_comb begin
      dec = '0;
      ok  = 1'b1;
      case (opcode)
         OP_LUI: begin
            dec.reg_write = 3'd6;
            dec.imm_type  = 3'd4;
            dec.alu_src2  = 2'b10;
            dec.alu_ctrl  = ac(10);
         end
         OP_AUIPC: begin
            dec.alu_src1  = 1'b1;
            dec.reg_write = 3'd6;
            dec.imm_type  = 3'd4;
            dec.alu_src2  = 2'b10;
            dec.alu_ctrl  = ac(3);
         end
         OP_JAL: begin
            dec.jal       = 1'b1;
            dec.load_npc  = 1'b1;
            dec.reg_write = 3'd6;
            dec.imm_type  = 3'd5;
         end
         OP_JALR: begin
            ok            = (fn3 == 3'b000);
            dec.jalr      = 1'b1;
            dec.load_npc  = 1'b1;
            dec.reg_write = 3'd6;
            dec.imm_type  = 3'd1;
            dec.reg_read  = 2'b10;
            dec.alu_src2  = 2'b10;
            dec.alu_ctrl  = ac(3);
         end
         OP_BRANCH: begin
            dec.imm_type = 3'd3;
            dec.reg_read = 2'b11;
            unique case (fn3)
               3'b000:  dec.branch_type = 3'd1;
               3'b001:  dec.branch_type = 3'd2;
               3'b100:  dec.branch_type = 3'd3;
               3'b101:  dec.branch_type = 3'd5;
               3'b110:  dec.branch_type = 3'd4;
               3'b111:  dec.branch_type = 3'd6;
               default: ok = 1'b0;
            endcase
         end
         OP_LOAD: begin
            dec.mem_to_reg = 1'b1;
            dec.imm_type   = 3'd1;
            dec.reg_read   = 2'b10;
            dec.alu_src2   = 2'b10;
            dec.alu_ctrl   = ac(3);
            unique case (fn3)
               3'b000:  dec.reg_write = 3'd1;
               3'b001:  dec.reg_write = 3'd2;
               3'b010:  dec.reg_write = 3'd3;
               3'b100:  dec.reg_write = 3'd4;
               3'b101:  dec.reg_write = 3'd5;
               default: ok = 1'b0;
            endcase
         end
         OP_STORE: begin
            dec.imm_type = 3'd2;
            dec.reg_read = 2'b11;
            dec.alu_src2 = 2'b10;
            dec.alu_ctrl = ac(3);
            unique case (fn3)
               3'b000:  dec.mem_write = 4'b0001;
               3'b001:  dec.mem_write = 4'b0011;
               3'b010:  dec.mem_write = 4'b1111;
               default: ok = 1'b0;
            endcase
         end
         OP_IMM: begin
            dec.reg_write = 3'd6;
            dec.imm_type  = 3'd1;
            dec.reg_read  = 2'b10;
            dec.alu_src2  = 2'b10;
            dec.alu_ctrl  = base_alu(fn3);
            // shift-immediates take shamt from the rs2 field
            if (fn3 == 3'b001) begin
               dec.alu_src2 = 2'b01;
               ok           = (fn7 == 7'b0000000);
            end else if (fn3 == 3'b101) begin
               dec.alu_src2 = 2'b01;
               if (fn7 == 7'b0100000)
                  dec.alu_ctrl = ac(2);
               else
                  ok = (fn7 == 7'b0000000);
            end
         end
         OP_REG: begin
            dec.reg_write = 3'd6;
            dec.reg_read  = 2'b11;
            if (fn7 == 7'b0000000) begin
               dec.alu_ctrl = base_alu(fn3);
            end else if (fn7 == 7'b0100000 && fn3 == 3'b000) begin
               dec.alu_ctrl = ac(4);
            end else if (fn7 == 7'b0100000 && fn3 == 3'b101) begin
               dec.alu_ctrl = ac(2);
            end else if (ENABLE_M != 0 && fn7 == 7'b0000001) begin
               dec.mul_div  = 1'b1;
               dec.is_div   = fn3[2];
               dec.alu_ctrl = ac(11 + int'(fn3));
            end else begin
               ok = 1'b0;
            end
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   // fresh marks the first EX cycle of the bundle, so a held op never restarts
   assign start = (state == IDLE) && fresh && e.mul_div;
   assign multi = e.is_div ? DIV_MULTI : MUL_MULTI;
   assign last  = (state == BUSY) && (cnt == 6'd0);

   assign MulDivStallReq = !FlushE &&
                           ((start && multi) ||
                            ((state == BUSY) && !last));
   assign MulDivDoneE    = !FlushE &&
                           ((start && !multi) || last);
   assign hold           = StallE || MulDivStallReq;

   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST || FlushE) begin
         e     <= '0;
         state <= IDLE;
         cnt   <= '0;
         fresh <= 1'b0;
      end else begin
         fresh <= !hold;
         if (!hold)
            e <= dec;
         case (state)
            IDLE: begin
               if (start && multi) begin
                  state <= BUSY;
                  cnt   <= e.is_div ? DIV_LD : MUL_LD;
               end
            end
            BUSY: begin
               if (cnt == 6'd0)
                  state <= IDLE;
               else
                  cnt <= cnt - 6'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign JalE        = e.jal;
   assign JalrE       = e.jalr;
   assign MemToRegE   = e.mem_to_reg;
   assign LoadNpcE    = e.load_npc;
   assign AluSrc1E    = e.alu_src1;
   assign RegWriteE   = e.reg_write;
   assign MemWriteE   = e.mem_write;
   assign RegReadE    = e.reg_read;
   assign BranchTypeE = e.branch_type;
   assign AluSrc2E    = e.alu_src2;
   assign ImmTypeE    = e.imm_type;
   assign AluContrlE  = e.alu_ctrl;
   assign MulDivE     = e.mul_div;
   assign IllegalE    = e.illegal;

endmodule

// File: tb/tb_muldiv_decode_stage.sv
// Scoreboard bench for muldiv_decode_stage: directed scenarios plus
// random instruction streams against a cycle-level reference model.
module tb_muldiv_decode_stage;

   localparam int MUL_C = 3;
   localparam int DIV_C = 33;

   localparam int ITAB [8] = '{3, 0, 8, 9, 5, 1, 6, 7};
   localparam int BTAB [8] = '{1, 2, 0, 0, 3, 5, 4, 6};
   localparam int LTAB [8] = '{1, 2, 3, 0, 4, 5, 0, 0};
   localparam int OPC [12] = '{'h37, 'h17, 'h6F, 'h67, 'h63, 'h03,
                               'h23, 'h13, 'h13, 'h33, 'h33, 'h7F};

   typedef struct packed {
      logic       jal;
      logic       jalr;
      logic       m2r;
      logic       npc;
      logic       src1;
      logic [2:0] rw;
      logic [3:0] mw;
      logic [1:0] rr;
      logic [2:0] bt;
      logic [1:0] src2;
      logic [2:0] imm;
      logic [4:0] alu;
      logic       md;
      logic       ill;
   } exp_t;

   typedef struct {
      logic [30:0] v1;
      logic [30:0] v2;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        stall_in = 1'b0;
   logic        flush_in = 1'b0;

   logic       jal1, jalr1, m2r1, npc1, src1_1, md1, ill1, sreq1, done1;
   logic [2:0] rw1, bt1, imm1;
   logic [3:0] mw1;
   logic [1:0] rr1, src2_1;
   logic [4:0] alu1;
   logic       jal2, jalr2, m2r2, npc2, src1_2, md2, ill2, sreq2, done2;
   logic [2:0] rw2, bt2, imm2;
   logic [3:0] mw2;
   logic [1:0] rr2, src2_2;
   logic [4:0] alu2;

   logic [30:0] act1, act2;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   rec_t q[$];

   exp_t m_cur = '0;
   exp_t m2_cur = '0;
   int   m_age = 0;
   bit   m_act = 1'b0;

   always #5 clk = ~clk;

   muldiv_decode_stage #(
      .ENABLE_M(1), .MUL_CYCLES(MUL_C),
      .DIV_CYCLES(DIV_C), .ALU_CTRL_W(5)
   ) dut (
      .CPU_CLK(clk), .CPU_RST(rst), .InstrD(instr),
      .StallE(stall_in), .FlushE(flush_in),
      .JalE(jal1), .JalrE(jalr1), .MemToRegE(m2r1),
      .LoadNpcE(npc1), .AluSrc1E(src1_1),
      .RegWriteE(rw1), .MemWriteE(mw1), .RegReadE(rr1),
      .BranchTypeE(bt1), .AluSrc2E(src2_1), .ImmTypeE(imm1),
      .AluContrlE(alu1), .MulDivE(md1), .IllegalE(ill1),
      .MulDivStallReq(sreq1), .MulDivDoneE(done1)
   );

   muldiv_decode_stage #(
      .ENABLE_M(0), .MUL_CYCLES(MUL_C),
      .DIV_CYCLES(DIV_C), .ALU_CTRL_W(5)
   ) dut_nom (
      .CPU_CLK(clk), .CPU_RST(rst), .InstrD(instr),
      .StallE(stall_in), .FlushE(flush_in),
      .JalE(jal2), .JalrE(jalr2), .MemToRegE(m2r2),
      .LoadNpcE(npc2), .AluSrc1E(src1_2),
      .RegWriteE(rw2), .MemWriteE(mw2), .RegReadE(rr2),
      .BranchTypeE(bt2), .AluSrc2E(src2_2), .ImmTypeE(imm2),
      .AluContrlE(alu2), .MulDivE(md2), .IllegalE(ill2),
      .MulDivStallReq(sreq2), .MulDivDoneE(done2)
   );

   assign act1 = {jal1, jalr1, m2r1, npc1, src1_1, rw1, mw1, rr1,
                  bt1, src2_1, imm1, alu1, md1, ill1, sreq1, done1};
   assign act2 = {jal2, jalr2, m2r2, npc2, src1_2, rw2, mw2, rr2,
                  bt2, src2_2, imm2, alu2, md2, ill2, sreq2, done2};

   // Architectural decode straight from the RV32I/M encoding tables
   function automatic exp_t ref_dec(input logic [31:0] w,
                                    input bit en_m);
      exp_t       e;
      bit         ok;
      logic [2:0] f3;
      logic [6:0] f7;
      e  = '0;
      ok = 1'b1;
      f3 = w[14:12];
      f7 = w[31:25];
      case (w[6:0])
         7'h37: begin
            e.rw = 3'd6; e.imm = 3'd4; e.src2 = 2'b10; e.alu = 5'd10;
         end
         7'h17: begin
            e.src1 = 1'b1; e.rw = 3'd6; e.imm = 3'd4;
            e.src2 = 2'b10; e.alu = 5'd3;
         end
         7'h6F: begin
            e.jal = 1'b1; e.npc = 1'b1; e.rw = 3'd6; e.imm = 3'd5;
         end
         7'h67: begin
            ok = (f3 == 3'd0);
            e.jalr = 1'b1; e.npc = 1'b1; e.rw = 3'd6; e.imm = 3'd1;
            e.rr = 2'b10; e.src2 = 2'b10; e.alu = 5'd3;
         end
         7'h63: begin
            e.bt = 3'(BTAB[f3]); ok = (BTAB[f3] != 0);
            e.imm = 3'd3; e.rr = 2'b11;
         end
         7'h03: begin
            e.rw = 3'(LTAB[f3]); ok = (LTAB[f3] != 0);
            e.m2r = 1'b1; e.imm = 3'd1; e.rr = 2'b10;
            e.src2 = 2'b10; e.alu = 5'd3;
         end
         7'h23: begin
            ok = (f3 < 3'd3);
            e.mw = (f3 == 3'd0) ? 4'h1 : (f3 == 3'd1) ? 4'h3 : 4'hF;
            e.imm = 3'd2; e.rr = 2'b11; e.src2 = 2'b10; e.alu = 5'd3;
         end
         7'h13: begin
            e.rw = 3'd6; e.imm = 3'd1; e.rr = 2'b10;
            e.src2 = 2'b10; e.alu = 5'(ITAB[f3]);
            if (f3 == 3'd1 || f3 == 3'd5) begin
               e.src2 = 2'b01;
               if (f3 == 3'd5 && f7 == 7'h20) e.alu = 5'd2;
               else ok = (f7 == 7'h00);
            end
         end
         7'h33: begin
            e.rw = 3'd6; e.rr = 2'b11;
            if (f7 == 7'h00) e.alu = 5'(ITAB[f3]);
            else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd4;
            else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd2;
            else if (f7 == 7'h01 && en_m) begin
               e.md = 1'b1; e.alu = 5'(11 + int'(f3));
            end else ok = 1'b0;
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e     = '0;
         e.ill = 1'b1;
      end
      return e;
   endfunction

   function automatic int ncyc(input exp_t e);
      return (e.alu >= 5'd15) ? DIV_C : MUL_C;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [31:0] w;
      int          k;
      w = $urandom;
      k = $urandom_range(0, 12);
      if (k == 12) return w;
      w[6:0] = 7'(OPC[k]);
      if (w[6:0] == 7'h67 && $urandom_range(0, 3) != 0)
         w[14:12] = 3'd0;
      if (w[6:0] == 7'h13 || w[6:0] == 7'h33) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
         endcase
      end
      return w;
   endfunction

   // Drive one cycle, queue the outputs expected during it, then advance
   task automatic step(input logic [31:0] w, input bit st,
                       input bit fl, input bit rs);
      rec_t r;
      int   c;
      bit   s_exp, d_exp;
      instr    = w;
      stall_in = st;
      flush_in = fl;
      rst      = rs;
      c     = ncyc(m_cur);
      s_exp = m_act && (m_age < c - 1) && !fl;
      d_exp = m_act && (m_age == c - 1) && !fl;
      r.v1  = {m_cur, s_exp, d_exp};
      r.v2  = {m2_cur, 2'b00};
      q.push_back(r);
      if (rs || fl) begin
         m_cur  = '0;
         m2_cur = '0;
         m_act  = 1'b0;
      end else begin
         if (m_act && m_age == c - 1) m_act = 1'b0;
         m_age++;
         if (!(st || s_exp)) begin
            m_cur = ref_dec(w, 1'b1);
            m_age = 0;
            m_act = m_cur.md;
         end
         if (!st) m2_cur = ref_dec(w, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [30:0] a,
                        input logic [30:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, a, x);
      end
   endtask

   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         cyc++;
         if (q.size() != 0) begin
            r = q.pop_front();
            check("dut", act1, r.v1);
            check("dut_nom", act2, r.v2);
         end
      end
   end

   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] ADD  = 32'h002081B3;
   localparam logic [31:0] MUL  = 32'h022081B3;
   localparam logic [31:0] DIV  = 32'h0220C1B3;
   localparam logic [31:0] DIVU = 32'h0220D1B3;
   localparam logic [31:0] SW   = 32'h0020A223;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      // ADD then MUL with a follower waiting in ID
      step(ADD, 0, 0, 0);
      step(MUL, 0, 0, 0);
      repeat (4) step(ADD, 0, 0, 0);
      // DIVU aborted by a flush on its 5th EX cycle
      step(DIVU, 0, 0, 0);
      repeat (4) step(NOP, 0, 0, 0);
      step(NOP, 0, 1, 0);
      repeat (2) step(NOP, 0, 0, 0);
      // SW behind a 2-cycle StallE
      step(ADD, 0, 0, 0);
      step(SW, 1, 0, 0);
      step(SW, 1, 0, 0);
      step(SW, 0, 0, 0);
      step(NOP, 0, 0, 0);
      // reset during BUSY cycle 10 of a DIV
      step(DIV, 0, 0, 0);
      repeat (10) step(NOP, 0, 0, 0);
      step(NOP, 0, 0, 1);
      repeat (2) step(NOP, 0, 0, 0);
      // illegal opcode, M word on the M-less instance, back-to-back M ops
      step(32'h0000007F, 0, 0, 0);
      step(MUL, 0, 0, 0);
      step(MUL, 0, 0, 0);
      step(MUL, 1, 0, 0);
      repeat (6) step(NOP, 0, 0, 0);
      for (int i = 0; i < 2500; i++) begin
         step(rnd_instr(),
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 149) == 0);
      end
      step(NOP, 0, 0, 0);
      @(posedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
